sorted_serializer: RTL and testbench

Output stage placed directly downstream of the 4-element, 2-bit odd-even sorter pipeline. It captures each sorted 8-bit word, buffers it in a small FIFO, and streams the four 2-bit elements out one per handshake over a valid/ready interface. It also checks that each captured word is correctly ordered and flags overflow when the sorter delivers faster than the consumer drains.

---
 rtl/sorted_serializer_if.sv | 35 +++
 rtl/sorted_serializer.sv | 122 ++++++++++++
 tb/tb_sorted_serializer.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/sorted_serializer_if.sv
// sorted_serializer_if
// Bundles the sorter-facing capture port and the consumer-facing
// valid/ready element stream of sorted_serializer, plus its status flags.
//   in_word   : packed sorted word, slot k = in_word[k*W_ELEM +: W_ELEM]
//   in_valid  : in_word valid this cycle (no backpressure toward the sorter)
//   out_data  : current element
//   out_valid : out_data valid
//   out_ready : consumer accepts out_data
//   out_last  : out_data is the final slot of its word
//   order_err : one-cycle pulse, captured word violated the expected order
//   overflow  : sticky, a word was dropped because the FIFO was full
// slave modport  = the serializer, master modport = the environment driving it.
interface sorted_serializer_if #(
    parameter int W_ELEM = 2,
    parameter int N_ELEM = 4
);
    logic [W_ELEM*N_ELEM-1:0] in_word;
    logic                     in_valid;
    logic [W_ELEM-1:0]        out_data;
    logic                     out_valid;
    logic                     out_ready;
    logic                     out_last;
    logic                     order_err;
    logic                     overflow;

    modport slave (
        input  in_word, in_valid, out_ready,
        output out_data, out_valid, out_last, order_err, overflow
    );

    modport master (
        output in_word, in_valid, out_ready,
        input  out_data, out_valid, out_last, order_err, overflow
    );
endinterface

// File: rtl/sorted_serializer.sv
// sorted_serializer
// Captures sorted words from the upstream sorter into a small FIFO and streams
// their elements (slot 0 first) one per valid/ready handshake. Each captured
// word is checked for ordering; words arriving while the FIFO is full (and the
// head is not popping that cycle) are dropped and flagged with a sticky overflow.
// Ports:
//   clk : clock, all logic on the rising edge
//   rst : synchronous active-high reset (pointers, count, index, flags cleared)
//   bus : sorted_serializer_if.slave (capture port, element stream, flags)
module sorted_serializer #(
    parameter int W_ELEM     = 2,
    parameter int N_ELEM     = 4,
    parameter int FIFO_DEPTH = 2,
    parameter bit DESCENDING = 1'b1
) (
    input  logic               clk,
    input  logic               rst,
    sorted_serializer_if.slave bus
);
    localparam int WORD_W = W_ELEM * N_ELEM;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam int IDX_W  = (N_ELEM > 1) ? $clog2(N_ELEM) : 1;

    logic [WORD_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic [IDX_W-1:0]  r_idx;
    logic              r_order_err;
    logic              r_overflow;

    logic              w_empty;
    logic              w_full;
    logic              w_fire;
    logic              w_last;
    logic              w_pop;
    logic              w_push;
    logic              w_drop;
    logic [WORD_W-1:0] w_head;
    logic [W_ELEM-1:0] w_head_slot [N_ELEM];
    logic [W_ELEM-1:0] w_in_slot   [N_ELEM];
    logic [N_ELEM-1:0] w_viol;
    logic [PTR_W-1:0]  w_wr_ptr_next;
    logic [PTR_W-1:0]  w_rd_ptr_next;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == CNT_W'(FIFO_DEPTH));
    assign w_fire  = !w_empty && bus.out_ready;
    assign w_last  = (r_idx == IDX_W'(N_ELEM - 1));
    assign w_pop   = w_fire && w_last;
    // A full FIFO still takes the new word when the head leaves in the same cycle.
    assign w_push  = bus.in_valid && (!w_full || w_pop);
    assign w_drop  = bus.in_valid && w_full && !w_pop;

    // Explicit wrap keeps FIFO_DEPTH=1 working with a 1-bit pointer.
    assign w_wr_ptr_next = (r_wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
    assign w_rd_ptr_next = (r_rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);

    assign w_head = r_mem[r_rd_ptr];

    generate
        for (genvar gi = 0; gi < N_ELEM; gi++) begin : g_slots
            assign w_head_slot[gi] = w_head[gi*W_ELEM +: W_ELEM];
            assign w_in_slot[gi]   = bus.in_word[gi*W_ELEM +: W_ELEM];
        end

        // One comparator per adjacent slot pair; equal neighbours are legal.
        for (genvar gi = 0; gi < N_ELEM - 1; gi++) begin : g_order
            if (DESCENDING) begin : g_desc
                assign w_viol[gi] = (w_in_slot[gi] < w_in_slot[gi+1]);
            end else begin : g_asc
                assign w_viol[gi] = (w_in_slot[gi] > w_in_slot[gi+1]);
            end
        end
        assign w_viol[N_ELEM-1] = 1'b0;
    endgenerate

    // Word storage: no reset needed, occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_wr_ptr] <= bus.in_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_idx       <= '0;
            r_order_err <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= w_wr_ptr_next;
            end
            if (w_pop) begin
                r_rd_ptr <= w_rd_ptr_next;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
            if (w_fire) begin
                r_idx <= w_last ? '0 : r_idx + IDX_W'(1);
            end
            // Checked on every presented word, accepted or dropped.
            r_order_err <= bus.in_valid && (|w_viol);
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    assign bus.out_valid = !w_empty;
    assign bus.out_data  = w_empty ? '0 : w_head_slot[r_idx];
    assign bus.out_last  = !w_empty && w_last;
    assign bus.order_err = r_order_err;
    assign bus.overflow  = r_overflow;
endmodule

// File: tb/tb_sorted_serializer.sv
module tb_sorted_serializer;
    logic clk;
    logic rst;

    sorted_serializer_if #(.W_ELEM(2), .N_ELEM(4)) if0 ();
    sorted_serializer_if #(.W_ELEM(2), .N_ELEM(4)) if1 ();

    sorted_serializer #(.W_ELEM(2), .N_ELEM(4), .FIFO_DEPTH(2), .DESCENDING(1'b1)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (if0.slave)
    );

    sorted_serializer #(.W_ELEM(2), .N_ELEM(4), .FIFO_DEPTH(2), .DESCENDING(1'b0)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (if1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] d;
        logic       l;
    } elem_t;

    elem_t q[$];
    logic  exp_err;
    logic  exp_ovf;
    int    n_vec;
    int    n_err;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic       ev;
        logic [1:0] ed;
        logic       el;
        ev = (q.size() != 0);
        ed = ev ? q[0].d : 2'd0;
        el = ev ? q[0].l : 1'b0;
        chk({tag, ".valid"}, {7'd0, if0.out_valid}, {7'd0, ev});
        chk({tag, ".data"},  {6'd0, if0.out_data},  {6'd0, ed});
        chk({tag, ".last"},  {7'd0, if0.out_last},  {7'd0, el});
        chk({tag, ".oerr"},  {7'd0, if0.order_err}, {7'd0, exp_err});
        chk({tag, ".ovf"},   {7'd0, if0.overflow},  {7'd0, exp_ovf});
    endtask

    // One clock: check what is presented now, then drive inputs for the next edge
    // and update the scoreboard with the handshake/push that edge will perform.
    task automatic cycle(input string tag, input logic v, input logic [7:0] w,
                         input logic rdy, input logic acc, input logic err);
        check_outputs(tag);
        if0.in_valid  = v;
        if0.in_word   = w;
        if0.out_ready = rdy;
        if (q.size() != 0 && rdy) begin
            $display("[%0t] %s xfer data=%0d last=%0b", $time, tag, q[0].d, q[0].l);
            void'(q.pop_front());
        end
        if (v && acc) begin
            for (int k = 0; k < 4; k++) begin
                q.push_back('{d: w[2*k +: 2], l: (k == 3)});
            end
            $display("[%0t] %s push word=%02h", $time, tag, w);
        end
        if (v && !acc) begin
            exp_ovf = 1'b1;
            $display("[%0t] %s drop word=%02h", $time, tag, w);
        end
        exp_err = err;
        @(negedge clk);
    endtask

    task automatic do_reset(input string tag);
        check_outputs(tag);
        rst           = 1'b1;
        if0.in_valid  = 1'b0;
        if0.in_word   = 8'h00;
        if0.out_ready = 1'b0;
        q.delete();
        exp_err = 1'b0;
        exp_ovf = 1'b0;
        $display("[%0t] %s reset", $time, tag);
        @(negedge clk);
        rst = 1'b0;
    endtask

    localparam logic [7:0] WA = 8'h1B; // slots 3,2,1,0
    localparam logic [7:0] WB = 8'h5A; // slots 2,2,1,1
    localparam logic [7:0] WC = 8'h03; // slots 3,0,0,0
    localparam logic [7:0] WD = 8'hC6; // slots 2,1,0,3 (out of order)

    initial begin
        n_vec = 0;
        n_err = 0;
        exp_err = 1'b0;
        exp_ovf = 1'b0;
        rst = 1'b1;
        if0.in_valid = 1'b0; if0.in_word = 8'h00; if0.out_ready = 1'b0;
        if1.in_valid = 1'b0; if1.in_word = 8'h00; if1.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_outputs("reset");
        rst = 1'b0;
        @(negedge clk);

        // Basic stream
        cycle("basic", 1'b1, WA, 1'b1, 1'b1, 1'b0);
        repeat (4) cycle("basic", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check_outputs("basic.idle");

        // Backpressure on slot1
        cycle("bp", 1'b1, WA, 1'b1, 1'b1, 1'b0);
        cycle("bp", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        repeat (3) cycle("bp.hold", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (3) cycle("bp", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check_outputs("bp.idle");

        // Overflow: A, B accepted, C dropped
        cycle("ovf", 1'b1, WA, 1'b0, 1'b1, 1'b0);
        cycle("ovf", 1'b1, WB, 1'b0, 1'b1, 1'b0);
        cycle("ovf", 1'b1, WC, 1'b0, 1'b0, 1'b0);
        repeat (3) cycle("ovf.hold", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (8) cycle("ovf.drain", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check_outputs("ovf.idle");
        do_reset("ovf.rst");

        // Order error: word still emitted unchanged
        cycle("oerr", 1'b1, WD, 1'b1, 1'b1, 1'b1);
        repeat (4) cycle("oerr", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check_outputs("oerr.idle");

        // Full FIFO with simultaneous last-slot pop and push
        cycle("fullpop", 1'b1, WA, 1'b0, 1'b1, 1'b0);
        cycle("fullpop", 1'b1, WB, 1'b0, 1'b1, 1'b0);
        repeat (3) cycle("fullpop", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        cycle("fullpop.same", 1'b1, WC, 1'b1, 1'b1, 1'b0);
        // Still full: a push without a pop must be dropped
        cycle("fullpop.full", 1'b1, WA, 1'b0, 1'b0, 1'b0);
        repeat (8) cycle("fullpop.drain", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check_outputs("fullpop.idle");
        do_reset("fullpop.rst");

        // Reset while slot2 is presented
        cycle("midrst", 1'b1, WA, 1'b1, 1'b1, 1'b0);
        repeat (2) cycle("midrst", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        do_reset("midrst.slot2");
        cycle("midrst.after", 1'b1, WB, 1'b1, 1'b1, 1'b0);
        repeat (4) cycle("midrst.new", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check_outputs("midrst.idle");

        // Ascending-order instance
        if1.in_word = 8'hE4; if1.in_valid = 1'b1;
        @(negedge clk);
        if1.in_valid = 1'b0;
        chk("asc.ok", {7'd0, if1.order_err}, 8'd0);
        $display("[%0t] asc word=e4 order_err=%0b", $time, if1.order_err);
        if1.in_word = WA; if1.in_valid = 1'b1;
        @(negedge clk);
        if1.in_valid = 1'b0;
        chk("asc.bad", {7'd0, if1.order_err}, 8'd1);
        $display("[%0t] asc word=1b order_err=%0b", $time, if1.order_err);
        @(negedge clk);
        chk("asc.pulse", {7'd0, if1.order_err}, 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
